// File: rtl/addr_stack_pkg.sv
// mcs4 package: program-counter operation codes and the default address type
// shared by the address stack and anything that drives it.
package mcs4;

   localparam int ADDR_W_DEFAULT = 12;

   typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

   // Encodings 6 and 7 are unused; the stack treats them as PC_HOLD.
   typedef enum logic [2:0] {
      PC_HOLD  = 3'd0,
      PC_INCR  = 3'd1,
      PC_JUMP  = 3'd2,
      PC_JPAGE = 3'd3,
      PC_CALL  = 3'd4,
      PC_RET   = 3'd5
   } pc_op_t;

endpackage

// File: rtl/addr_stack_incr.sv
// addr_incr: ADDR_W-bit +1 incrementer producing the next sequential address.
// The carry out of the top bit is dropped, so the all-ones address wraps to 0.
//   a : current address
//   y : (a + 1) mod 2^ADDR_W
module addr_incr #(
   parameter int ADDR_W = 12
) (
   input  logic [ADDR_W-1:0] a,
   output logic [ADDR_W-1:0] y
);

   assign y = a + ADDR_W'(1);

endmodule

// File: rtl/addr_stack.sv
// addr_stack: program counter plus a circular return-address stack.
// The PC is its own register; DEPTH-1 return slots form a small unreset RAM
// addressed by a wrapping stack pointer. CALL at full depth overwrites the
// oldest slot (ovf), RET at depth 0 still pops the wrapped slot (unf).
//   clk, rst : clock, synchronous active-high reset
//   op_en    : qualifies op; all state holds when low
//   op, tgt  : operation and its target address
//   nib_sel  : nibble index for nib_out
//   pc       : registered program counter
//   nib_out  : selected 4-bit nibble of pc (combinational)
//   depth    : number of valid return slots
//   ovf, unf : registered one-cycle overflow / underflow pulses
module addr_stack
   import mcs4::*;
#(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         op_en,
   input  pc_op_t                       op,
   input  logic [ADDR_W-1:0]            tgt,
   input  logic [$clog2(ADDR_W/4)-1:0]  nib_sel,
   output logic [ADDR_W-1:0]            pc,
   output logic [3:0]                   nib_out,
   output logic [$clog2(DEPTH)-1:0]     depth,
   output logic                         ovf,
   output logic                         unf
);

   localparam int NIBS  = ADDR_W / 4;
   localparam int NW    = $clog2(NIBS);
   localparam int SLOTS = DEPTH - 1;
   localparam int SP_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int DW    = $clog2(DEPTH);
   localparam logic [SP_W-1:0]   SP_LAST  = SP_W'(SLOTS - 1);
   localparam logic [DW-1:0]     DEPTH_MX = DW'(SLOTS);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(8'hFF);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [DW-1:0]     depth_q, depth_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic [ADDR_W-1:0] slot_q [SLOTS];
   logic              slot_we;

   logic [ADDR_W-1:0] pc1;
   logic [ADDR_W-1:0] jpage;
   logic [SP_W-1:0]   sp_next, sp_prev;

   addr_incr #(.ADDR_W(ADDR_W)) u_incr (
      .a (pc_q),
      .y (pc1)
   );

   // Page of the next address with the low byte taken from tgt; a mask form
   // keeps this legal when ADDR_W is exactly 8 (no page bits).
   assign jpage   = (pc1 & ~LOW_MASK) | (tgt & LOW_MASK);
   assign sp_next = (sp_q == SP_LAST) ? '0 : sp_q + SP_W'(1);
   assign sp_prev = (sp_q == '0) ? SP_LAST : sp_q - SP_W'(1);

   always_comb begin
      pc_d    = pc_q;
      sp_d    = sp_q;
      depth_d = depth_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      slot_we = 1'b0;
      if (op_en) begin
         case (op)
            PC_INCR:  pc_d = pc1;
            PC_JUMP:  pc_d = tgt;
            PC_JPAGE: pc_d = jpage;
            PC_CALL: begin
               slot_we = 1'b1;
               sp_d    = sp_next;
               pc_d    = tgt;
               if (depth_q == DEPTH_MX) ovf_d = 1'b1;
               else                     depth_d = depth_q + DW'(1);
            end
            PC_RET: begin
               sp_d = sp_prev;
               pc_d = slot_q[sp_prev];
               if (depth_q == '0) unf_d = 1'b1;
               else               depth_d = depth_q - DW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         sp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Return slots behave as RAM: no reset, and a CALL coincident with reset
   // does not write.
   always_ff @(posedge clk) begin
      if (slot_we && !rst) slot_q[sp_q] <= pc1;
   end

   always_comb begin
      nib_out = 4'h0;
      for (int i = 0; i < NIBS; i++) begin
         if (nib_sel == NW'(i)) nib_out = pc_q[i*4 +: 4];
      end
   end

   assign pc    = pc_q;
   assign depth = depth_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: doc/addr_stack.md
ADDR_STACK -- requirements
Module: addr_stack

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: program-address width in bits; multiple of 4, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 4: total address-register levels (PC plus DEPTH-1 return slots); minimum 2.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port op_en  input  1: qualifies op; when low, all state holds.
REQ-006 SHALL have port op  input  mcs4::pc_op_t: PC_HOLD, PC_INCR, PC_JUMP, PC_JPAGE, PC_CALL, PC_RET.
REQ-007 SHALL have port tgt  input  ADDR_W: target address for JUMP/JPAGE/CALL.
REQ-008 SHALL have port nib_sel  input  $clog2(ADDR_W/4): nibble index for address-cycle output.
REQ-009 SHALL have port pc  output  ADDR_W: current program counter, registered.
REQ-010 SHALL have port nib_out  output  4: pc[nib_sel*4 +: 4], combinational from pc and nib_sel.
REQ-011 SHALL have port depth  output  $clog2(DEPTH): number of valid return slots, 0..DEPTH-1.
REQ-012 SHALL have port ovf  output  1: one-cycle pulse, CALL executed at full depth.
REQ-013 SHALL have port unf  output  1: one-cycle pulse, RET executed at depth 0.

Function
REQ-014 SHALL execute an op on every rising edge with op_en=1; result visible on pc/depth the next cycle; no backpressure.
REQ-015 SHALL define pc1 = (pc+1) mod 2^ADDR_W; 0xFFF+1 wraps to 0x000 silently at ADDR_W=12.
REQ-016 PC_HOLD SHALL leave all state unchanged; PC_INCR SHALL load pc1.
REQ-017 PC_JUMP SHALL load tgt.
REQ-018 PC_JPAGE SHALL load {pc1[ADDR_W-1:8], tgt[7:0]} (page of next address).
REQ-019 PC_CALL SHALL write pc1 to slot sp, advance sp modulo DEPTH-1, load tgt into pc.
REQ-020 PC_CALL at depth<DEPTH-1 SHALL increment depth; at depth=DEPTH-1 SHALL keep depth, overwrite oldest slot, pulse ovf.
REQ-021 PC_RET SHALL retreat sp modulo DEPTH-1 and load slot sp-1 into pc.
REQ-022 PC_RET at depth>0 SHALL decrement depth; at depth=0 SHALL keep depth 0, still load wrapped slot, pulse unf.
REQ-023 ovf and unf SHALL be registered, high exactly the cycle after the offending op, otherwise low.
REQ-024 Unused op encodings SHALL behave as PC_HOLD.

Reset
REQ-025 rst SHALL force pc=0, sp=0, depth=0, ovf=0, unf=0 on the next edge, overriding any simultaneous op_en/op.
REQ-026 Return-slot contents SHALL be left unreset (stack RAM); RET after reset returns undefined-but-stable data only via unf path.

Structure
REQ-027 pc_op_t enum and addr_t (ADDR_W=12 default) SHALL live in package mcs4.
REQ-028 Return slots SHALL be a DEPTH-1 entry register array indexed by sp; pc SHALL be a separate register.
REQ-029 Incrementer SHALL be a sub-module addr_incr (ADDR_W-bit +1, carry-out unused).

Verification
REQ-030 Reset, then INCR from pc=0xFFF -> pc=0x000, depth=0, ovf=unf=0.
REQ-031 JUMP 0x2FF, JPAGE tgt=0x034 -> pc=0x334; nib_sel=2 -> nib_out=0x3, nib_sel=0 -> 0x4.
REQ-032 JUMP 0x010; CALL 0x100; CALL 0x200; CALL 0x300 -> depth=3; RET x3 -> pc 0x201, 0x101, 0x011, depth 0.
REQ-033 Fourth CALL 0x400 at depth 3 -> ovf high one cycle, depth=3; RET x3 -> 0x301, 0x201, 0x101 (0x011 lost).
REQ-034 RET at depth 0 -> unf high one cycle, depth stays 0; op_en=0 with op=PC_CALL -> no change.
REQ-035 rst asserted same edge as CALL 0x100 at depth 2 -> pc=0, depth=0, ovf=0.
